alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked execute-stage ALU for the simple ARM core. Single-cycle logic/arith/shift
//  ops with registered result; iterative multiply and unsigned divide/remainder over multiple cycles.
//  Produces NZCV flags and a divide-by-zero flag. Sits between decode/issue and writeback.
// PARAMETERS
//  WIDTH   32  operand/result width; >=8, power of two
//  MUL_EN  1   1: MUL implemented; 0: MUL behaves as default (pass in_0)
//  DIV_EN  1   1: DIVU/REMU implemented; 0: behave as default (pass in_0)
// PORTS
//  clk        in   1      clock; all state on rising edge
//  reset      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous abort: drop in-flight op and pending result
//  in_valid   in   1      operand/op valid
//  in_ready   out  1      block accepts op this cycle (in_valid && in_ready = accept)
//  op         in   4      operation code (shared ALU_OP_* encodings)
//  in_0       in   WIDTH  operand A
//  in_1       in   WIDTH  operand B / shift amount in low log2(WIDTH) bits
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result (out_valid && out_ready = drain)
//  out        out  WIDTH  result
//  flags      out  4      {N,Z,C,V} for the result on out
//  dz         out  1      result came from DIVU/REMU with in_1==0
//  busy       out  1      multi-cycle op in progress
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out=0, flags=0, dz=0, busy=0; in_ready=1 after reset release.
//  Ops: AND, OR (true bitwise OR), XOR, ADDS, ADDU, SUBS, SUBU, SHRL, SHLL, SHRA (arith),
//   MUL (low WIDTH bits of product), DIVU, REMU; undefined codes -> out=in_0, flags N/Z only.
//  Shift amount = in_1[log2(WIDTH)-1:0]; upper bits ignored.
//  Flags: N=out[WIDTH-1]; Z=(out==0); C: ADD* carry-out, SUB* = NOT borrow (ARM), shifts = last bit
//   shifted out (amount 0 -> C=0), else 0; V: ADDS/SUBS two's-complement overflow from sign bits
//   (A,B,result), else 0.
//  FSM IDLE/BUSY. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Single-cycle op accepted at edge t -> out/flags registered, out_valid=1 from t+1.
//   Back-to-back with out_ready=1 gives 1 result/cycle.
//  MUL/DIVU/REMU accepted at t -> BUSY, busy=1, operands latched; WIDTH iterations (shift-add /
//   restoring divide), one per cycle; result registered, out_valid=1 at t+WIDTH+1, state->IDLE.
//  Divide by zero: DIVU -> all ones, REMU -> in_0, dz=1; latency unchanged.
//  out/flags/dz held stable while out_valid && !out_ready; out_valid clears on drain without new result.
//  Simultaneous drain and accept: new result replaces old, out_valid stays 1.
//  flush: same cycle as accept -> op discarded; in BUSY -> IDLE, busy=0; out_valid=0 next edge;
//   flush has priority over accept and drain.
//  Reset mid-operation: immediate return to reset values; no partial result ever appears.
//  Inputs sampled only on accept; operand changes during BUSY have no effect.
// STRUCTURE
//  Shared package (isa.vh/cpu.vh): ALU_OP_* codes (4-bit), FLAG_N/Z/C/V bit indices, ENABLE/DISABLE.
//  Sub-module alu_iter_muldiv: start/done iterative MUL/DIVU/REMU engine, WIDTH-parameterised,
//   counter of log2(WIDTH)+1 bits; alu_seq owns FSM, handshake, single-cycle datapath, flag logic.
// TESTING (WIDTH=32)
//  ADDS 7FFFFFFF+00000001 -> out=80000000, NZCV=1001, out_valid one cycle after accept.
//  SUBU 3-5 -> FFFFFFFE, NZCV=1000; OR F0|0F -> 000000FF; SHRA 80000000 by 4 -> F8000000, C=0.
//  MUL 00010000*00010001 -> 00010000, out_valid exactly 33 cycles after accept, busy high 32 cycles.
//  DIVU 100/7 -> 14, REMU -> 2, dz=0; DIVU 5/0 -> FFFFFFFF, dz=1; REMU 5/0 -> 5, dz=1.
//  out_ready=0 for 3 cycles: out/flags stable, in_ready=0; then 4 back-to-back ADDU with out_ready=1
//   -> 4 results on 4 consecutive cycles.
//  reset low mid-MUL -> out_valid=0, busy=0 immediately; flush mid-DIVU -> IDLE, no result emitted.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU op codes, flag bit positions and mul/div engine op selector.
//   Exports ALU_OP_* (4-bit), FLAG_N/Z/C/V indices into {N,Z,C,V}, ENABLE/DISABLE,
//   md_op_e and md_sel() mapping an ALU op code onto the iterative engine's operation.
package alu_seq_pkg;
    localparam logic [3:0] ALU_OP_AND  = 4'd0;
    localparam logic [3:0] ALU_OP_OR   = 4'd1;
    localparam logic [3:0] ALU_OP_XOR  = 4'd2;
    localparam logic [3:0] ALU_OP_ADDS = 4'd3;
    localparam logic [3:0] ALU_OP_ADDU = 4'd4;
    localparam logic [3:0] ALU_OP_SUBS = 4'd5;
    localparam logic [3:0] ALU_OP_SUBU = 4'd6;
    localparam logic [3:0] ALU_OP_SHRL = 4'd7;
    localparam logic [3:0] ALU_OP_SHLL = 4'd8;
    localparam logic [3:0] ALU_OP_SHRA = 4'd9;
    localparam logic [3:0] ALU_OP_MUL  = 4'd10;
    localparam logic [3:0] ALU_OP_DIVU = 4'd11;
    localparam logic [3:0] ALU_OP_REMU = 4'd12;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_op_e;

    function automatic md_op_e md_sel(input logic [3:0] op);
        return op == ALU_OP_MUL ? MD_MUL : op == ALU_OP_DIVU ? MD_DIVU : MD_REMU;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/result handshake bundle for alu_seq.
//   master (issuer/consumer) drives flush, in_valid, op, in_0, in_1, out_ready;
//   slave (alu_seq) drives in_ready, out_valid, out, flags {N,Z,C,V}, dz, busy.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             dz;
    logic             busy;

    modport master (
        output flush, in_valid, op, in_0, in_1, out_ready,
        input  in_ready, out_valid, out, flags, dz, busy
    );
    modport slave (
        input  flush, in_valid, op, in_0, in_1, out_ready,
        output in_ready, out_valid, out, flags, dz, busy
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_iter_muldiv: iterative shift-add multiply / restoring unsigned divide, one bit per cycle.
//   clk, reset (async active-low), flush (abort), start + md_op/a/b (operands latched on start),
//   done (high once WIDTH iterations finished, until next start), result, dz (divisor was zero).
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  md_op_e           md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);
    localparam int LG = $clog2(WIDTH);
    localparam logic [LG:0] LAST = (LG+1)'(WIDTH);

    // MUL: x=accumulator, y=multiplier (shifts right), z=multiplicand (shifts left)
    // DIV: x=remainder, y=dividend shifting out / quotient shifting in, z=divisor
    logic [LG:0]      cnt;
    logic [WIDTH-1:0] x, y, z, sub;
    logic [WIDTH:0]   r_sh;
    logic             ge;
    md_op_e           op_q;

    // zero divisor always takes the subtract path, yielding quotient all ones and remainder = dividend
    always_comb begin
        r_sh = {x, y[WIDTH-1]};
        ge   = r_sh >= {1'b0, z};
        sub  = r_sh[WIDTH-1:0] - z;
    end

    assign done   = cnt == LAST;
    assign result = op_q == MD_DIVU ? y : x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= LAST;
            x    <= '0;
            y    <= '0;
            z    <= '0;
            op_q <= MD_MUL;
            dz   <= 1'b0;
        end else if (flush) begin
            cnt <= LAST;
        end else if (start) begin
            cnt  <= '0;
            x    <= '0;
            y    <= md_op == MD_MUL ? b : a;
            z    <= md_op == MD_MUL ? a : b;
            op_q <= md_op;
            dz   <= md_op != MD_MUL && b == '0;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
            x   <= op_q == MD_MUL ? (y[0] ? x + z : x) : (ge ? sub : r_sh[WIDTH-1:0]);
            y   <= op_q == MD_MUL ? y >> 1 : {y[WIDTH-2:0], ge};
            z   <= op_q == MD_MUL ? z << 1 : z;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered single-cycle ops and iterative MUL/DIVU/REMU.
//   clk, reset (async active-low), bus (alu_seq_if.slave): flush, in_valid/in_ready, op, in_0, in_1,
//   out_valid/out_ready, out, flags {N,Z,C,V}, dz, busy.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = ENABLE,
    parameter bit DIV_EN = ENABLE
) (
    input  logic clk,
    input  logic reset,
    alu_seq_if.slave bus
);
    localparam int LG = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a, b, res, res_q, md_res;
    logic [LG-1:0]    sh;
    logic [3:0]       flg_q;
    logic             c, v, ov, dz_q, accept, is_md, start, md_done, md_dz;

    assign a  = bus.in_0;
    assign b  = bus.in_1;
    assign sh = b[LG-1:0];

    assign bus.in_ready  = state == IDLE && (!ov || bus.out_ready);
    assign bus.out_valid = ov;
    assign bus.out       = res_q;
    assign bus.flags     = flg_q;
    assign bus.dz        = dz_q;
    // the engine's finished-but-not-yet-registered cycle is not counted as busy
    assign bus.busy      = state == BUSY && !md_done;

    assign accept = bus.in_valid && bus.in_ready;
    assign is_md  = (MUL_EN && bus.op == ALU_OP_MUL) ||
                    (DIV_EN && (bus.op == ALU_OP_DIVU || bus.op == ALU_OP_REMU));
    assign start  = accept && is_md && !bus.flush;

    // shifts carry an extra bit on the outgoing side so C is the last bit shifted out (0 for amount 0);
    // subtraction with a leading 1 leaves NOT borrow in the carry position
    always_comb begin
        res = a;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.op)
            ALU_OP_AND: res = a & b;
            ALU_OP_OR:  res = a | b;
            ALU_OP_XOR: res = a ^ b;
            ALU_OP_ADDS, ALU_OP_ADDU: begin
                {c, res} = {1'b0, a} + {1'b0, b};
                v = bus.op == ALU_OP_ADDS && a[M] == b[M] && res[M] != a[M];
            end
            ALU_OP_SUBS, ALU_OP_SUBU: begin
                {c, res} = {1'b1, a} - {1'b0, b};
                v = bus.op == ALU_OP_SUBS && a[M] != b[M] && res[M] != a[M];
            end
            ALU_OP_SHRL: {res, c} = {a, 1'b0} >> sh;
            ALU_OP_SHLL: {c, res} = {1'b0, a} << sh;
            ALU_OP_SHRA: {res, c} = $signed({a, 1'b0}) >>> sh;
            default: ;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .flush (bus.flush),
        .start (start),
        .md_op (md_sel(bus.op)),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .result(md_res),
        .dz    (md_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ov    <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
            dz_q  <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            ov    <= 1'b0;
        end else begin
            if (bus.out_ready) ov <= 1'b0;
            if (accept && !is_md) begin
                ov    <= 1'b1;
                res_q <= res;
                flg_q <= {res[M], res == '0, c, v};
                dz_q  <= 1'b0;
            end
            if (start) state <= BUSY;
            if (state == BUSY && md_done) begin
                state <= IDLE;
                ov    <= 1'b1;
                res_q <= md_res;
                flg_q <= {md_res[M], md_res == '0, 2'b00};
                dz_q  <= md_dz;
            end
        end
    end
endmodule
